// File: rtl/btn_pkg.sv
// Shared types and default timing constants for push-button conditioning.
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    CHK_PRESS,
    PRESSED,
    CHK_RELEASE
  } btn_state_t;

  localparam int DEBOUNCE_CYCLES_50MHZ_10MS = 500000;
  localparam int LONG_CYCLES_1S             = 50000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, parameterised reset level.
// Latency: 2 cycles from d to q.
// Backpressure: none; free-running.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Push-button synchroniser + bounce filter with press/release pulses; long_press under BTN_LONG_PRESS_EN.
// Latency: 2 + DEBOUNCE_CYCLES + 1 cycles from a clean pad edge to btn_level/pulse.
// Backpressure: none; pulses are single-cycle and must be consumed when seen.
module button_debouncer
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ_10MS,
  parameter int CNT_W           = 20,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int LONG_CYCLES     = LONG_CYCLES_1S
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
`ifdef BTN_LONG_PRESS_EN
  ,
  output logic long_press
`endif
);

  localparam logic             REL_LEVEL = ACTIVE_LOW;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q;
  logic             sample;
  logic             cnt_done;
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_d, press_d, release_d;

  // Reset to the released pad level so a held button is re-qualified from scratch.
  sync_2ff #(
    .RESET_VAL(REL_LEVEL)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (btn_raw),
    .q    (sync_q)
  );

  assign sample   = sync_q ^ ACTIVE_LOW;
  assign cnt_done = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      RELEASED: begin
        if (sample) state_d = CHK_PRESS;
      end
      CHK_PRESS: begin
        if (!sample)       state_d = RELEASED;
        else if (cnt_done) state_d = PRESSED;
        else               cnt_d   = cnt_q + 1'b1;
      end
      PRESSED: begin
        if (!sample) state_d = CHK_RELEASE;
      end
      CHK_RELEASE: begin
        if (sample)        state_d = PRESSED;
        else if (cnt_done) state_d = RELEASED;
        else               cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = RELEASED;
    endcase
  end

  always_comb begin
    level_d   = (state_d == PRESSED) || (state_d == CHK_RELEASE);
    press_d   = (state_q == CHK_PRESS)   && (state_d == PRESSED);
    release_d = (state_q == CHK_RELEASE) && (state_d == RELEASED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      btn_level     <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int                HOLD_W    = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_d;

  // Hold count survives a bounce through CHK_RELEASE so a brief chatter does not restart it.
  always_comb begin
    case (state_q)
      PRESSED:     hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 1'b1;
      CHK_RELEASE: hold_d = hold_q;
      default:     hold_d = '0;
    endcase
    long_d = ((state_d == PRESSED) || (state_d == CHK_RELEASE)) &&
             (long_press || ((state_q == PRESSED) && (hold_q == HOLD_LAST)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q     <= '0;
      long_press <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      long_press <= long_d;
    end
  end
`else
  logic unused_long_cfg;
  assign unused_long_cfg = (LONG_CYCLES > 0);
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, LONG_CYCLES=16, active-low pad.
module tb_button_debouncer;

  logic clk = 1'b0;
  logic reset;
  logic btn_raw;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
`ifdef BTN_LONG_PRESS_EN
  logic long_press;
`endif

  int checks   = 0;
  int failures = 0;

  button_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (2),
    .ACTIVE_LOW     (1'b1),
    .LONG_CYCLES    (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
`ifdef BTN_LONG_PRESS_EN
    ,
    .long_press   (long_press)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle so outputs are sampled away from the clock edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = 1'b1;

    // Reset with pad released.
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("rst_level k=%0d", k), 32'(btn_level), 32'd0);
      check($sformatf("rst_press k=%0d", k), 32'(press_pulse), 32'd0);
      check($sformatf("rst_release k=%0d", k), 32'(release_pulse), 32'd0);
`ifdef BTN_LONG_PRESS_EN
      check($sformatf("rst_long k=%0d", k), 32'(long_press), 32'd0);
`endif
    end
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("idle_level k=%0d", k), 32'(btn_level), 32'd0);
    end

    // Clean press: pulse on the 7th edge after the pad change.
    btn_raw = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("press_pulse k=%0d", k), 32'(press_pulse), 32'(k == 7));
      check($sformatf("press_level k=%0d", k), 32'(btn_level), 32'(k >= 7));
      check($sformatf("press_rel k=%0d", k), 32'(release_pulse), 32'd0);
`ifdef BTN_LONG_PRESS_EN
      check($sformatf("press_long k=%0d", k), 32'(long_press), 32'd0);
`endif
    end

    // Chatter while pressed: 2-cycle high runs never qualify a release.
    for (int k = 1; k <= 20; k++) begin
      btn_raw = ((((k - 1) >> 1) & 1) == 0);
      step();
      check($sformatf("chat_level k=%0d", k), 32'(btn_level), 32'd1);
      check($sformatf("chat_rel k=%0d", k), 32'(release_pulse), 32'd0);
      check($sformatf("chat_press k=%0d", k), 32'(press_pulse), 32'd0);
    end
    btn_raw = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("chat_hold k=%0d", k), 32'(btn_level), 32'd1);
      check($sformatf("chat_hold_rel k=%0d", k), 32'(release_pulse), 32'd0);
    end

    // Release with a 3-cycle low glitch on edges 3..5: the counter restarts,
    // release lands 7 edges after the pad settles high (edge 12).
    for (int k = 1; k <= 16; k++) begin
      btn_raw = !((k >= 3) && (k <= 5));
      step();
      check($sformatf("glitch_rel k=%0d", k), 32'(release_pulse), 32'(k == 12));
      check($sformatf("glitch_level k=%0d", k), 32'(btn_level), 32'(k < 12));
      check($sformatf("glitch_press k=%0d", k), 32'(press_pulse), 32'd0);
    end

    // Reset during CHK_PRESS, then requalify the held button from scratch.
    btn_raw = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("mid_press k=%0d", k), 32'(press_pulse), 32'd0);
      check($sformatf("mid_level k=%0d", k), 32'(btn_level), 32'd0);
    end
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("mid_rst_press k=%0d", k), 32'(press_pulse), 32'd0);
      check($sformatf("mid_rst_level k=%0d", k), 32'(btn_level), 32'd0);
    end
    reset = 1'b0;
    for (int j = 1; j <= 37; j++) begin
      step();
      check($sformatf("req_press j=%0d", j), 32'(press_pulse), 32'(j == 7));
      check($sformatf("req_level j=%0d", j), 32'(btn_level), 32'(j >= 7));
`ifdef BTN_LONG_PRESS_EN
      check($sformatf("long_rise j=%0d", j), 32'(long_press), 32'(j >= 23));
`endif
    end

    // Clean release after the long hold.
    btn_raw = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("rel_pulse k=%0d", k), 32'(release_pulse), 32'(k == 7));
      check($sformatf("rel_level k=%0d", k), 32'(btn_level), 32'(k < 7));
      check($sformatf("rel_press k=%0d", k), 32'(press_pulse), 32'd0);
`ifdef BTN_LONG_PRESS_EN
      check($sformatf("long_fall k=%0d", k), 32'(long_press), 32'(k < 7));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
